// File: rtl/cpu_types_pkg.sv
// Shared types and defaults for the memory arbiter.
// word_t is the 32-bit datapath word; arb_state_t is the arbiter FSM state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

    // Consecutive data grants allowed while an instruction fetch waits.
    localparam int DEF_IFAIR_LIMIT = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every non-clock signal around the memory arbiter, with views
// for the arbiter itself, the cache/request side and the RAM side.
//
// Handshake: a requester raises REN/WEN and holds address/data steady
// until it sees its wait signal low; wait low for one cycle means the
// access completed in that cycle. A requester that drops REN/WEN before
// then abandons the access and receives no acknowledge.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic  nRST;
    logic  iREN;
    word_t iaddr;
    logic  dREN;
    logic  dWEN;
    word_t daddr;
    word_t dstore;
    word_t ramload;
    logic  ramready;
    logic  iwait;
    logic  dwait;
    word_t iload;
    word_t dload;
    logic  ramREN;
    logic  ramWEN;
    word_t ramaddr;
    word_t ramstore;

    modport arb (
        input  nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport cache (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  iwait, dwait, iload, dload
    );

    modport ram (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramready
    );

endinterface

// File: rtl/arb_stat_counter.sv
// 32-bit enable counter with synchronous active-low clear. Wraps modulo 2^32.
// Used by mem_arbiter only when MEM_ARB_STATS_EN is defined.
module arb_stat_counter
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  clr_n,
    input  logic  en,
    output word_t count
);

    // Count enabled cycles; clear has priority.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction fetches and data accesses onto one RAM port.
// Data has priority; a saturating starvation counter forces an instruction
// grant after IFAIR_LIMIT consecutive data grants with a fetch pending.
// Optional build macro MEM_ARB_STATS_EN adds completed-access counters
// icount/dcount.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int IFAIR_LIMIT = DEF_IFAIR_LIMIT,
    parameter int CNT_W       = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] icount,
    output logic [31:0] dcount
`endif
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(IFAIR_LIMIT);

    arb_state_t       state;
    arb_state_t       next_state;
    logic [CNT_W-1:0] cnt;
    logic             d_any;

    // A write with dREN also high is still a write; dREN only matters alone.
    assign d_any = dREN | dWEN;

    // Grant decision and access completion / abandonment.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (d_any && !(iREN && (cnt == LIMIT))) begin
                    next_state = DACC;
                end else if (iREN) begin
                    next_state = IACC;
                end
            end
            IACC: begin
                if (!iREN || ramready) begin
                    next_state = IDLE;
                end
            end
            DACC: begin
                if (!d_any || ramready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register and saturating starvation counter.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (!iREN) begin
                cnt <= '0;
            end else if (state == IDLE && next_state == IACC) begin
                cnt <= '0;
            end else if (state == IDLE && next_state == DACC && cnt != LIMIT) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Output decode; while nRST is low the port looks idle so no strobe or
    // acknowledge escapes during the reset cycle.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (nRST) begin
            case (state)
                IACC: begin
                    ramREN  = iREN;
                    ramaddr = iaddr;
                    if (iREN && ramready) begin
                        iwait = 1'b0;
                        iload = ramload;
                    end
                end
                DACC: begin
                    ramaddr = daddr;
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = dREN;
                    end
                    if (d_any && ramready) begin
                        dwait = 1'b0;
                        dload = dWEN ? '0 : ramload;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic i_done;
    logic d_done;

    assign i_done = nRST && (state == IACC) && iREN && ramready;
    assign d_done = nRST && (state == DACC) && d_any && ramready;

    arb_stat_counter u_icount (
        .clk   (CLK),
        .clr_n (nRST),
        .en    (i_done),
        .count (icount)
    );

    arb_stat_counter u_dcount (
        .clk   (CLK),
        .clr_n (nRST),
        .en    (d_done),
        .count (dcount)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all
// checked each cycle against a transaction-level reference of the arbiter.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] ramload;
    logic        ramready;
    logic        iwait;
    logic        dwait;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] icount;
    logic [31:0] dcount;
`endif

    mem_arbiter dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .ramload  (ramload),
        .ramready (ramready),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore)
`ifdef MEM_ARB_STATS_EN
        ,
        .icount   (icount),
        .dcount   (dcount)
`endif
    );

    // Clock
    always #5 CLK = ~CLK;

    // Counters
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference model: who owns the RAM (0 none, 1 fetch, 2 data), how many
    // data grants have gone by while the current fetch waited, grant log.
    int          m_busy   = 0;
    int          m_streak = 0;
    string       glog     = "";
    bit          i_ack;
    bit          d_ack;
    int unsigned m_icnt   = 0;
    int unsigned m_dcnt   = 0;

    // Requester / RAM behaviour knobs
    int          i_left   = 0;
    int          d_left   = 0;
    int unsigned rdy_pct  = 100;
    int unsigned wd_pct   = 0;
    int unsigned wr_pct   = 50;

    task automatic chk1(string tag, logic obs, logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_str(string tag, string obs, string exp);
        n_total++;
        assert (obs == exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
        end
    endtask

    // One clock: predict outputs from the rules, compare mid-cycle, advance.
    task automatic tick();
        logic        e_rren;
        logic        e_rwen;
        logic        e_iw;
        logic        e_dw;
        logic [31:0] e_addr;
        logic [31:0] e_store;
        logic [31:0] e_il;
        logic [31:0] e_dl;
        bit          c_addr;
        bit          c_store;
        bit          c_il;
        bit          c_dl;
        int          nxt;
        @(negedge CLK);
        e_rren = 1'b0; e_rwen = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
        e_addr = '0; e_store = '0; e_il = '0; e_dl = '0;
        c_addr = 0; c_store = 0; c_il = 0; c_dl = 0;
        i_ack = 0; d_ack = 0;
        nxt = m_busy;
        if (!nRST || m_busy == 0) begin
            c_addr = 1; c_store = 1; c_il = 1; c_dl = 1;
        end
        if (!nRST) begin
            nxt = 0;
            m_streak = 0;
        end else if (m_busy == 0) begin
            if ((dREN || dWEN) && !(iREN && m_streak == LIMIT)) begin
                nxt = 2;
                glog = {glog, "D"};
                if (iREN && m_streak < LIMIT) m_streak++;
            end else if (iREN) begin
                nxt = 1;
                glog = {glog, "I"};
                m_streak = 0;
            end
        end else if (m_busy == 1) begin
            e_rren = iREN;
            e_addr = iaddr;
            c_addr = iREN;
            if (!iREN) nxt = 0;
            else if (ramready) begin
                i_ack = 1; e_iw = 1'b0; e_il = ramload; c_il = 1; nxt = 0;
            end
        end else begin
            if (dWEN) begin
                e_rwen = 1'b1; e_store = dstore; c_store = 1;
            end else begin
                e_rren = dREN;
            end
            e_addr = daddr;
            c_addr = dREN || dWEN;
            if (!(dREN || dWEN)) nxt = 0;
            else if (ramready) begin
                d_ack = 1; e_dw = 1'b0; e_dl = dWEN ? 32'd0 : ramload; c_dl = 1; nxt = 0;
            end
        end
        if (!iREN) m_streak = 0;

        chk1("iwait", iwait, e_iw);
        chk1("dwait", dwait, e_dw);
        chk1("ramREN", ramREN, e_rren);
        chk1("ramWEN", ramWEN, e_rwen);
        if (c_addr)  chk32("ramaddr", ramaddr, e_addr);
        if (c_store) chk32("ramstore", ramstore, e_store);
        if (c_il)    chk32("iload", iload, e_il);
        if (c_dl)    chk32("dload", dload, e_dl);
`ifdef MEM_ARB_STATS_EN
        chk32("icount", icount, m_icnt);
        chk32("dcount", dcount, m_dcnt);
`endif
        if (!nRST) begin
            m_icnt = 0; m_dcnt = 0;
        end else begin
            if (i_ack) m_icnt++;
            if (d_ack) m_dcnt++;
        end
        m_busy = nxt;
        @(posedge CLK);
        #1;
    endtask

    // Driver tasks: issue the next request of each stream, if any remain.
    task automatic new_i();
        if (i_left > 0) begin
            i_left--;
            iREN  = 1'b1;
            iaddr = $urandom & 32'hFFFF_FFFC;
        end else begin
            iREN = 1'b0;
        end
    endtask

    task automatic new_d();
        if (d_left > 0) begin
            d_left--;
            dWEN   = ($urandom_range(0, 99) < wr_pct);
            dREN   = dWEN ? 1'($urandom_range(0, 1)) : 1'b1;
            daddr  = $urandom;
            dstore = $urandom;
        end else begin
            dREN = 1'b0;
            dWEN = 1'b0;
        end
    endtask

    task automatic auto_tick();
        ramready = ($urandom_range(0, 99) < rdy_pct);
        ramload  = $urandom;
        tick();
        if (i_ack || !iREN) new_i();
        else if ($urandom_range(0, 99) < wd_pct) iREN = 1'b0;
        if (d_ack || !(dREN || dWEN)) new_d();
        else if ($urandom_range(0, 99) < wd_pct) begin
            dREN = 1'b0;
            dWEN = 1'b0;
        end
    endtask

    task automatic drain(int budget);
        bit done = 0;
        for (int k = 0; k < budget; k++) begin
            if (!iREN && !dREN && !dWEN && i_left == 0 && d_left == 0 && m_busy == 0) begin
                done = 1;
                break;
            end
            auto_tick();
        end
        chk1("drain_in_budget", done, 1'b1);
    endtask

    initial begin
        // Reset with a fetch already requested
        nRST = 1'b0; iREN = 1'b1; iaddr = 32'h40;
        dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
        ramload = '0; ramready = 1'b0;
        tick();
        tick();
        chk_str("reset_no_grant", glog, "");

        // Single fetch, RAM answers in the second access cycle
        nRST = 1'b1; iREN = 1'b0;
        tick();
        iREN = 1'b1; iaddr = 32'h40;
        tick();
        tick();
        chk1("fetch_wait_first_cycle", i_ack, 1'b0);
        ramready = 1'b1; ramload = 32'h8C22_0004;
        tick();
        chk1("fetch_ack", i_ack, 1'b1);
        iREN = 1'b0; ramready = 1'b0;
        tick();
        chk_str("fetch_grants", glog, "I");

        // Simultaneous fetch and write: data first, then fetch
        glog = ""; rdy_pct = 100; wd_pct = 0;
        iREN = 1'b1; iaddr = 32'h44;
        dWEN = 1'b1; dREN = 1'b0; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        drain(20);
        chk_str("priority_order", glog, "DI");

        // Starvation bound: fetch held against six data reads
        glog = ""; wr_pct = 0; i_left = 2; d_left = 6;
        new_i();
        new_d();
        drain(60);
        chk_str("starvation_order", glog, "DDDDIDDI");

        // Data read withdrawn before ramready
        dREN = 1'b1; daddr = 32'h200; ramready = 1'b0;
        tick();
        tick();
        dREN = 1'b0;
        tick();
        chk1("abort_no_ack", d_ack, 1'b0);
        tick();

        // Reset asserted mid-fetch
        iREN = 1'b1; iaddr = 32'h80;
        tick();
        tick();
        nRST = 1'b0; ramready = 1'b1;
        tick();
        chk1("reset_mid_fetch_no_ack", i_ack, 1'b0);
        nRST = 1'b1; iREN = 1'b0; ramready = 1'b0;
        tick();

        // Randomized mixed traffic with slow RAM and rare withdrawals
        rdy_pct = 60; wd_pct = 3; wr_pct = 50;
        i_left = 150; d_left = 150;
        new_i();
        new_d();
        drain(5000);

        // Completed-access counts after a clean reset
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        rdy_pct = 100; wd_pct = 0; i_left = 3; d_left = 2;
        new_i();
        new_d();
        drain(100);
`ifdef MEM_ARB_STATS_EN
        chk32("icount_after_3", icount, 32'd3);
        chk32("dcount_after_2", dcount, 32'd2);
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        tick();
        chk32("icount_cleared", icount, 32'd0);
        chk32("dcount_cleared", dcount, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the request unit and the instruction/data cache paths.
- Consumes instruction fetch requests (imemREN) and data requests (dmemREN/dmemWEN) and serialises them onto the single-ported RAM.
- Returns per-requester wait/load signals.
- Data accesses have priority; a bounded-starvation counter guarantees instruction fetch progress.

Parameters:
- IFAIR_LIMIT, 4: maximum consecutive data grants while an instruction request is pending; the next grant is then forced to instruction.
- CNT_W, 3: width of the starvation counter; must satisfy 2**CNT_W > IFAIR_LIMIT.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  reset, synchronous, active-low.
- iREN  input  1  instruction read request; held until iwait=0.
- iaddr  input  32  instruction word address.
- dREN  input  1  data read request; held until dwait=0.
- dWEN  input  1  data write request; held until dwait=0.
- daddr  input  32  data address.
- dstore  input  32  write data.
- ramload  input  32  RAM read data.
- ramready  input  1  RAM access complete this cycle.
- iwait  output  1  instruction requester must stall.
- dwait  output  1  data requester must stall.
- iload  output  32  instruction read data.
- dload  output  32  data read data.
- ramREN  output  1  RAM read strobe.
- ramWEN  output  1  RAM write strobe.
- ramaddr  output  32  RAM address.
- ramstore  output  32  RAM write data.

Behaviour:
- State register arb_state_t: IDLE, IACC, DACC; reset and power-up value IDLE. Reset clears the starvation counter.
- All outputs are combinational from state and inputs.
  - In IDLE: ram* = 0, iload = dload = 0, iwait = dwait = 1.
  - Reset therefore yields iwait = dwait = 1 and all other outputs 0.
- IDLE transitions:
  - If (dREN|dWEN) and not (iREN and cnt==IFAIR_LIMIT), go to DACC.
  - Else if iREN, go to IACC.
  - Else stay in IDLE.
- IACC:
  - ramREN=1, ramaddr=iaddr.
  - When ramready=1: iwait=0, iload=ramload, next state IDLE.
  - Otherwise iwait=1.
- DACC:
  - ramaddr=daddr.
  - If dWEN: ramWEN=1, ramstore=dstore. Else ramREN=1.
  - When ramready=1: dwait=0, dload=ramload (reads only; 0 on writes), next state IDLE.
- The non-granted requester always sees wait=1.
- Minimum latency: request seen in IDLE at cycle N, RAM strobe in cycle N+1, earliest wait=0 in cycle N+1 (ramready same cycle). Back-to-back accesses have a one-cycle IDLE gap.
- dREN and dWEN both high: treated as a write; dREN ignored.
- Request withdrawn mid-access (the granted REN/WEN drops before ramready): return to IDLE next cycle. No wait=0 pulse; the RAM strobe deasserts immediately.
- Starvation counter cnt:
  - Increments on each IDLE->DACC transition while iREN=1.
  - Clears on IDLE->IACC, or on any cycle with iREN=0.
  - Saturates at IFAIR_LIMIT.
- nRST low mid-access: next edge forces IDLE and cnt=0; RAM strobes drop that cycle; no acknowledge is issued.
- RAM contract: ramready is honoured only in IACC/DACC and is ignored in IDLE.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- When defined:
  - Adds output ports icount[31:0] and dcount[31:0].
  - Each counts completed accesses (ramready in IACC or DACC respectively) and wraps modulo 2^32.
  - Both reset to 0 on nRST low.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- cpu_types_pkg holds:
  - word_t (32-bit).
  - arb_state_t enum {IDLE, IACC, DACC}.
  - Default IFAIR_LIMIT constant.
- Interface mem_arbiter_if declares all non-clock signals, with modport arb plus cache-side and ram-side modports.
- One natural sub-module, arb_stat_counter: a 32-bit enable counter with synchronous active-low clear, instantiated twice, only under MEM_ARB_STATS_EN.

Test Plan:
- Reset: hold nRST=0 two cycles with iREN=1 -> iwait=dwait=1, ramREN=ramWEN=0, state IDLE.
- Single fetch: iREN=1, iaddr=0x40, RAM answers ramload=0x8C220004 with ramready in the second access cycle -> ramREN=1, ramaddr=0x40 for 2 cycles, iwait=0 and iload=0x8C220004 on the second, then IDLE.
- Priority: iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEADBEEF) simultaneously, ramready immediate -> data serviced first (ramWEN=1, ramstore=0xDEADBEEF), instruction granted after one IDLE cycle.
- Starvation: iREN held high with 6 back-to-back data reads, IFAIR_LIMIT=4 -> grant order D,D,D,D,I,D,D.
- Abort: dREN drops in DACC before ramready -> ramREN=0 the same cycle, dwait never 0, IDLE next cycle; reset asserted mid-IACC -> IDLE and no iwait=0.
- Stats (MEM_ARB_STATS_EN): 3 fetches and 2 data accesses complete -> icount=3, dcount=2; nRST pulse -> both 0.
